// File: rtl/riscv_pkg.sv
// Shared load/store encodings and the responder FSM state type.
package riscv_pkg;

  // funct3 encodings for loads
  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

  // funct3 encodings for stores
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word out of a stored word and extends it.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by sign or zero extension by access type.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    byte_sel = word_i[{byte_off_i, 3'b000} +: 8];
    half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
    data_o   = word_i;
    case (funct3_i)
      LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data_o = {24'h0, byte_sel};
      LH:      data_o = {{16{half_sel[15]}}, half_sel};
      LHU:     data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_resp.sv
// Single-port data memory with a two-state request/response handshake.
module data_mem_resp
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_r_en_i,
  input  logic        mem_wr_en_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        wack_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic        rvalid_q, rvalid_d;
  logic        wack_q, wack_d;
  logic        err_q, err_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word_q;
  logic [31:0] aligned;

  logic [AW-1:0] word_idx;
  logic          bad;
  logic          do_rd, do_wr;
  logic [3:0]    be;
  logic [31:0]   wlane;

  assign word_idx = addr_i[AW+1:2];

  // Classify the presented request: illegal encoding, misalignment, range, both strobes.
  always_comb begin
    bad = 1'b0;
    if (mem_r_en_i && mem_wr_en_i) begin
      bad = 1'b1;
    end else if (mem_r_en_i) begin
      if (!(funct3_i inside {LB, LH, LW, LBU, LHU})) bad = 1'b1;
    end else begin
      if (!(funct3_i inside {SB, SH, SW})) bad = 1'b1;
    end
    if (funct3_i[1:0] == 2'd1 && addr_i[0])          bad = 1'b1;
    if (funct3_i[1:0] == 2'd2 && addr_i[1:0] != 2'd0) bad = 1'b1;
    if (addr_i[31:2] >= 30'(DEPTH))                  bad = 1'b1;
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be    = 4'b0000;
    wlane = wdata_i;
    case (funct3_i)
      SB: begin
        be    = 4'b0001 << addr_i[1:0];
        wlane = {4{wdata_i[7:0]}};
      end
      SH: begin
        be    = addr_i[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_i[15:0]}};
      end
      SW: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Next-state and response decode: any strobe in IDLE moves to RESP for one cycle.
  always_comb begin
    state_d  = state_q;
    rvalid_d = 1'b0;
    wack_d   = 1'b0;
    err_d    = 1'b0;
    off_d    = off_q;
    f3_d     = f3_q;
    do_rd    = 1'b0;
    do_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_r_en_i || mem_wr_en_i) begin
          state_d = RESP;
          if (bad) begin
            err_d = 1'b1;
          end else if (mem_r_en_i) begin
            rvalid_d = 1'b1;
            do_rd    = 1'b1;
            off_d    = addr_i[1:0];
            f3_d     = funct3_i;
          end else begin
            wack_d = 1'b1;
            do_wr  = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and response registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      err_q    <= 1'b0;
      off_q    <= 2'd0;
      f3_q     <= 3'd0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      wack_q   <= wack_d;
      err_q    <= err_d;
      off_q    <= off_d;
      f3_q     <= f3_d;
    end
  end

  // Storage port: byte-enabled write and registered read, suppressed while in reset.
  always_ff @(posedge clk_i) begin
    // NOTE: the array and its read register have no reset so the storage can map onto block RAM.
    if (do_wr && !rst_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
    if (do_rd && !rst_i) begin
      rd_word_q <= mem[word_idx];
    end
  end

  load_align u_load_align (
    .word_i     (rd_word_q),
    .byte_off_i (off_q),
    .funct3_i   (f3_q),
    .data_o     (aligned)
  );

  assign ready_o  = (state_q == IDLE);
  assign rvalid_o = rvalid_q;
  assign wack_o   = wack_q;
  assign err_o    = err_q;
  assign rdata_o  = rvalid_q ? aligned : 32'h0;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed-vector bench for data_mem_resp.
module tb_data_mem_resp;

  localparam int unsigned DEPTH = 1024;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_r_en_i;
  logic        mem_wr_en_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        wack_o;
  logic        err_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  data_mem_resp #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mem_r_en_i  (mem_r_en_i),
    .mem_wr_en_i (mem_wr_en_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .ready_o     (ready_o),
    .rdata_o     (rdata_o),
    .rvalid_o    (rvalid_o),
    .wack_o      (wack_o),
    .err_o       (err_o)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rv;
    logic        wa;
    logic        er;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic rv, input logic wa,
                              input logic er, input logic [31:0] rdata);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rv = rv; v.wa = wa; v.er = er; v.rdata = rdata;
    return v;
  endfunction

  // {ready, rvalid, wack, err, rdata}
  function automatic logic [35:0] status();
    return {ready_o, rvalid_o, wack_o, err_o, rdata_o};
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    mem_r_en_i  = rd;
    mem_wr_en_i = wr;
    funct3_i    = f3;
    addr_i      = addr;
    wdata_i     = wdata;
  endtask

  localparam logic [35:0] IDLE_ST = {1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (2) @(negedge clk_i);
    check("reset_state", status(), IDLE_ST);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_reset_idle", status(), IDLE_ST);

    vecs.push_back(mk("sw_10",       0, 1, 3'd2, 32'h10,   32'hDEADBEEF, 0, 1, 0, 32'h0));
    vecs.push_back(mk("lw_10",       1, 0, 3'd2, 32'h10,   32'h0,        1, 0, 0, 32'hDEADBEEF));
    vecs.push_back(mk("sw_10_zero",  0, 1, 3'd2, 32'h10,   32'h0,        0, 1, 0, 32'h0));
    vecs.push_back(mk("sb_13",       0, 1, 3'd0, 32'h13,   32'h80,       0, 1, 0, 32'h0));
    vecs.push_back(mk("lb_13",       1, 0, 3'd0, 32'h13,   32'h0,        1, 0, 0, 32'hFFFFFF80));
    vecs.push_back(mk("lbu_13",      1, 0, 3'd4, 32'h13,   32'h0,        1, 0, 0, 32'h00000080));
    vecs.push_back(mk("lw_10_sb",    1, 0, 3'd2, 32'h10,   32'h0,        1, 0, 0, 32'h80000000));
    vecs.push_back(mk("lh_11_mis",   1, 0, 3'd1, 32'h11,   32'h0,        0, 0, 1, 32'h0));
    vecs.push_back(mk("sw_12_mis",   0, 1, 3'd2, 32'h12,   32'h12345678, 0, 0, 1, 32'h0));
    vecs.push_back(mk("lw_10_keep",  1, 0, 3'd2, 32'h10,   32'h0,        1, 0, 0, 32'h80000000));
    vecs.push_back(mk("both_strobe", 1, 1, 3'd2, 32'h10,   32'h11111111, 0, 0, 1, 32'h0));
    vecs.push_back(mk("ld_f3_3",     1, 0, 3'd3, 32'h10,   32'h0,        0, 0, 1, 32'h0));
    vecs.push_back(mk("lw_oob",      1, 0, 3'd2, 32'h1000, 32'h0,        0, 0, 1, 32'h0));
    vecs.push_back(mk("sw_oob",      0, 1, 3'd2, 32'h1FFC, 32'h0,        0, 0, 1, 32'h0));
    vecs.push_back(mk("lw_10_after",  1, 0, 3'd2, 32'h10,   32'h0,        1, 0, 0, 32'h80000000));
    vecs.push_back(mk("sw_last",     0, 1, 3'd2, 32'hFFC,  32'hCAFEF00D, 0, 1, 0, 32'h0));
    vecs.push_back(mk("lw_last",     1, 0, 3'd2, 32'hFFC,  32'h0,        1, 0, 0, 32'hCAFEF00D));
    vecs.push_back(mk("sw_20",       0, 1, 3'd2, 32'h20,   32'h11223344, 0, 1, 0, 32'h0));
    vecs.push_back(mk("sh_22",       0, 1, 3'd1, 32'h22,   32'h1234ABCD, 0, 1, 0, 32'h0));
    vecs.push_back(mk("lw_20_sh",    1, 0, 3'd2, 32'h20,   32'h0,        1, 0, 0, 32'hABCD3344));
    vecs.push_back(mk("lh_22",       1, 0, 3'd1, 32'h22,   32'h0,        1, 0, 0, 32'hFFFFABCD));
    vecs.push_back(mk("lhu_22",      1, 0, 3'd5, 32'h22,   32'h0,        1, 0, 0, 32'h0000ABCD));
    vecs.push_back(mk("lh_20",       1, 0, 3'd1, 32'h20,   32'h0,        1, 0, 0, 32'h00003344));
    vecs.push_back(mk("lb_21",       1, 0, 3'd0, 32'h21,   32'h0,        1, 0, 0, 32'h00000033));
    vecs.push_back(mk("st_f3_4",     0, 1, 3'd4, 32'h20,   32'hFFFFFFFF, 0, 0, 1, 32'h0));
    vecs.push_back(mk("sb_21",       0, 1, 3'd0, 32'h21,   32'hFFFFFF9C, 0, 1, 0, 32'h0));
    vecs.push_back(mk("lw_20_sb",    1, 0, 3'd2, 32'h20,   32'h0,        1, 0, 0, 32'hABCD9C44));
    vecs.push_back(mk("lb_21_neg",   1, 0, 3'd0, 32'h21,   32'h0,        1, 0, 0, 32'hFFFFFF9C));

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      @(negedge clk_i);
      check(vecs[i].name, status(), {1'b0, vecs[i].rv, vecs[i].wa, vecs[i].er, vecs[i].rdata});
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      @(negedge clk_i);
      check({vecs[i].name, "_idle"}, status(), IDLE_ST);
    end

    // Strobe held high: accepted every other cycle, ready toggles.
    drive(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) check($sformatf("hold_%0d", i), status(), IDLE_ST);
      else            check($sformatf("hold_%0d", i), status(), {4'b0100, 32'h80000000});
      @(negedge clk_i);
    end
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk_i);
    check("hold_done", status(), IDLE_ST);

    // Reset during a load response discards it.
    drive(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    @(negedge clk_i);
    check("rst_resp_pending", status(), {4'b0100, 32'h80000000});
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_resp_dropped", status(), IDLE_ST);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_resp_ready", status(), IDLE_ST);

    // Store accepted before reset stays committed; store coincident with reset is ignored.
    drive(1'b0, 1'b1, 3'd2, 32'h30, 32'h5A5A5A5A);
    @(negedge clk_i);
    check("sw_30_ack", status(), {4'b0010, 32'h0});
    rst_i = 1'b1;
    drive(1'b0, 1'b1, 3'd2, 32'h30, 32'hFFFFFFFF);
    @(negedge clk_i);
    check("sw_during_rst", status(), IDLE_ST);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);
    drive(1'b1, 1'b0, 3'd2, 32'h30, 32'h0);
    @(negedge clk_i);
    check("lw_30_kept", status(), {4'b0100, 32'h5A5A5A5A});
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
